// File: rtl/adc_fill_sequencer.sv
// Per-trigger ADC fill sequencer: acquisition window, readout handoff,
// fill numbering and lost-trigger accounting.
module adc_fill_sequencer #(
    parameter int FILL_W = 24,
    parameter int WIN_W  = 16,
    parameter int LOST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [FILL_W-1:0] initial_fill_num,
    input  logic              arm,
    input  logic              trigger,
    input  logic [WIN_W-1:0]  acq_len,
    input  logic              rd_ready,
    output logic              acq_en,
    output logic              fill_valid,
    output logic [FILL_W-1:0] fill_num,
    output logic              busy,
    output logic [LOST_W-1:0] trig_lost
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        HANDOFF
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        init_ff;
    logic              init_sync;
    logic              trig_acc;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic [LOST_W-1:0] lost_nxt;

    assign init_sync = init_ff[1];
    assign trig_acc  = arm & trigger;

    // Outputs decode the state register only, so nothing flows from inputs.
    assign acq_en     = (state == ACQ);
    assign fill_valid = (state == HANDOFF);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_ff   <= 2'b00;
            state     <= IDLE;
            win_cnt   <= '0;
            fill_num  <= '0;
            trig_lost <= '0;
        end else begin
            init_ff   <= {init_ff[0], init};
            state     <= state_nxt;
            win_cnt   <= win_nxt;
            fill_num  <= fill_nxt;
            trig_lost <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        fill_nxt  = fill_num;
        lost_nxt  = trig_lost;
        if (init_sync) begin
            state_nxt = IDLE;
            win_nxt   = '0;
            fill_nxt  = initial_fill_num;
            lost_nxt  = '0;
        end else begin
            if (trig_acc && state != IDLE && trig_lost != {LOST_W{1'b1}}) begin
                lost_nxt = trig_lost + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trig_acc) begin
                        state_nxt = ACQ;
                        win_nxt   = (acq_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : acq_len;
                    end
                end
                ACQ: begin
                    win_nxt = win_cnt - 1'b1;
                    if (win_cnt <= {{(WIN_W-1){1'b0}}, 1'b1}) begin
                        state_nxt = HANDOFF;
                    end
                end
                HANDOFF: begin
                    if (rd_ready) begin
                        fill_nxt  = fill_num + 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
